// File: rtl/alu_issue.sv
// alu_issue: issue/writeback sequencer for an external registered ALU.
// Holds a 4 x 8-bit register file and a 4-bit flag register, and walks each
// instruction through IDLE -> ISSUE -> WB (three cycles from accept to done).
// Optional feature: define ALU_ISSUE_IMM_EN to decode instr[12] as the
// immediate-form select (alu_b = imm8, alu_shamt = instr[2:0]). When it is
// undefined, every instruction uses the register form and instr[12] is ignored.
module alu_issue (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        instr_valid,
  input  logic [15:0] instr,
  output logic        instr_ready,
  output logic [7:0]  alu_a,
  output logic [7:0]  alu_b,
  output logic [2:0]  alu_op,
  output logic [2:0]  alu_shamt,
  input  logic [7:0]  alu_out,
  input  logic [3:0]  alu_flags,
  output logic [3:0]  flags,
  output logic        done,
  input  logic [1:0]  rd_sel,
  output logic [7:0]  rd_data
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ISSUE = 2'd1;
  localparam logic [1:0] ST_WB    = 2'd2;

  logic [1:0]  state_q, state_d;
  logic [15:0] instr_q, instr_d;
  logic [7:0]  regs_q [4];
  logic [7:0]  regs_d [4];
  logic [3:0]  flags_q, flags_d;
  logic        done_q, done_d;

  // Field views of the latched instruction word.
  logic [2:0] op_f;
  logic [1:0] rd_f;
  logic [1:0] ra_f;
  logic [1:0] rb_f;

  assign op_f = instr_q[15:13];
  assign rd_f = instr_q[11:10];
  assign ra_f = instr_q[9:8];
  assign rb_f = instr_q[1:0];

`ifndef ALU_ISSUE_IMM_EN
  // Without the immediate form the select bit and rb[7:5] carry no meaning.
  logic unused_imm_bits;
  assign unused_imm_bits = ^{instr_q[12], instr_q[7:5]};
`endif

  // Next-state logic: accept in IDLE, one cycle of issue, then writeback.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path
    // leaves a variable unassigned and no latch is inferred.
    state_d = state_q;
    instr_d = instr_q;
    regs_d  = regs_q;
    flags_d = flags_q;
    done_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (instr_valid) begin
          instr_d = instr;
          state_d = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        state_d = ST_WB;
      end
      ST_WB: begin
        // Operands were read in ISSUE, so rd == ra/rb simply overwrites.
        regs_d[rd_f] = alu_out;
        flags_d      = alu_flags;
        done_d       = 1'b1;
        state_d      = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // ALU operand drive: live only in ISSUE, parked at zero otherwise.
  always_comb begin
    alu_a     = 8'h00;
    alu_b     = 8'h00;
    alu_op    = 3'd0;
    alu_shamt = 3'd0;
    if (state_q == ST_ISSUE) begin
      alu_a  = regs_q[ra_f];
      alu_op = op_f;
`ifdef ALU_ISSUE_IMM_EN
      if (instr_q[12]) begin
        alu_b     = instr_q[7:0];
        alu_shamt = instr_q[2:0];
      end else begin
        alu_b     = regs_q[rb_f];
        alu_shamt = instr_q[4:2];
      end
`else
      alu_b     = regs_q[rb_f];
      alu_shamt = instr_q[4:2];
`endif
    end
  end

  // State, latched instruction, register file, flags and done pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      instr_q <= 16'h0000;
      // NOTE: the register file is architecturally visible after reset, so
      // it is reset like any flop rather than left to power-up contents.
      regs_q  <= '{default: 8'h00};
      flags_q <= 4'h0;
      done_q  <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      state_q <= state_d;
      instr_q <= instr_d;
      regs_q  <= regs_d;
      flags_q <= flags_d;
      done_q  <= done_d;
    end
  end

  assign instr_ready = (state_q == ST_IDLE);
  assign flags       = flags_q;
  assign done        = done_q;
  assign rd_data     = regs_q[rd_sel];

endmodule

// File: tb/tb_alu_issue.sv
// tb_alu_issue: directed self-checking bench for alu_issue.
// A behavioural ALU stands in for the external unit; a register-file model
// pushes the expected writeback of every accepted instruction onto a
// scoreboard that is popped whenever done pulses.
// ALU flag convention used by the stand-in: Z=3, N=2, C=1 (carry out /
// no-borrow / last bit shifted out), V=0 (result did not fit in 8 unsigned
// bits: add carry, sub borrow, LSL lost nonzero bits).
module tb_alu_issue;

  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_SUB = 3'd1;
  localparam logic [2:0] OP_AND = 3'd2;
  localparam logic [2:0] OP_ORR = 3'd3;
  localparam logic [2:0] OP_EOR = 3'd4;
  localparam logic [2:0] OP_LSL = 3'd5;
  localparam logic [2:0] OP_LSR = 3'd6;
  localparam logic [2:0] OP_MVN = 3'd7;

  typedef struct {
    logic [1:0] rd;
    logic [7:0] val;
    logic [3:0] flg;
    int         hs;
  } exp_t;

  logic        clk;
  logic        rst_n;
  logic        instr_valid;
  logic [15:0] instr;
  logic        instr_ready;
  logic [7:0]  alu_a;
  logic [7:0]  alu_b;
  logic [2:0]  alu_op;
  logic [2:0]  alu_shamt;
  logic [7:0]  alu_out;
  logic [3:0]  alu_flags;
  logic [3:0]  flags;
  logic        done;
  logic [1:0]  rd_sel;
  logic [7:0]  rd_data;

  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc      = 0;
  int   done_cnt = 0;
  exp_t sb[$];
  exp_t mon_e;
  logic [7:0] mreg [4];

  alu_issue dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .instr_valid(instr_valid),
    .instr      (instr),
    .instr_ready(instr_ready),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_op     (alu_op),
    .alu_shamt  (alu_shamt),
    .alu_out    (alu_out),
    .alu_flags  (alu_flags),
    .flags      (flags),
    .done       (done),
    .rd_sel     (rd_sel),
    .rd_data    (rd_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Stand-in ALU: returns {Z, N, C, V, result}.
  function automatic logic [11:0] alu_f(input logic [2:0] op, input logic [7:0] a,
                                        input logic [7:0] b, input logic [2:0] sh);
    logic [8:0]  s;
    logic [15:0] w;
    logic [7:0]  o;
    logic        c;
    logic        v;
    s = '0; w = '0; o = '0; c = 1'b0; v = 1'b0;
    case (op)
      OP_ADD: begin s = {1'b0, a} + {1'b0, b}; o = s[7:0]; c = s[8];  v = s[8]; end
      OP_SUB: begin s = {1'b0, a} - {1'b0, b}; o = s[7:0]; c = ~s[8]; v = s[8]; end
      OP_AND: o = a & b;
      OP_ORR: o = a | b;
      OP_EOR: o = a ^ b;
      OP_LSL: begin w = {8'h00, a} << sh; o = w[7:0];  c = w[8]; v = |w[15:8]; end
      OP_LSR: begin w = {a, 8'h00} >> sh; o = w[15:8]; c = w[7]; end
      default: o = ~b;
    endcase
    return {(o == 8'h00), o[7], c, v, o};
  endfunction

  // Registered ALU: result of the ISSUE cycle is presented during WB.
  always @(posedge clk) {alu_flags, alu_out} <= alu_f(alu_op, alu_a, alu_b, alu_shamt);

  function automatic logic [15:0] enc_r(input logic [2:0] op, input logic [1:0] rd,
                                        input logic [1:0] ra, input logic [1:0] rb,
                                        input logic [2:0] sh);
    return {op, 1'b0, rd, ra, 3'b000, sh, rb};
  endfunction

  function automatic logic [15:0] enc_i(input logic [2:0] op, input logic [1:0] rd,
                                        input logic [1:0] ra, input logic [7:0] imm);
    return {op, 1'b1, rd, ra, imm};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_checks++;
    assert (obs === exp_v) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  // Operands the DUT should present for word w, taken from the model.
  task automatic operands(input logic [15:0] w, output logic [7:0] a,
                          output logic [7:0] b, output logic [2:0] sh);
    a  = mreg[w[9:8]];
    b  = mreg[w[1:0]];
    sh = w[4:2];
`ifdef ALU_ISSUE_IMM_EN
    if (w[12]) begin
      b  = w[7:0];
      sh = w[2:0];
    end
`endif
  endtask

  // Compute the expected writeback, update the model, queue the expectation.
  task automatic predict(input logic [15:0] w);
    logic [7:0]  a, b;
    logic [2:0]  sh;
    logic [11:0] r;
    exp_t        e;
    operands(w, a, b, sh);
    r     = alu_f(w[15:13], a, b, sh);
    e.rd  = w[11:10];
    e.val = r[7:0];
    e.flg = r[11:8];
    e.hs  = cyc;
    mreg[w[11:10]] = r[7:0];
    sb.push_back(e);
  endtask

  // Hand one instruction over, then check the ISSUE and WB cycles; returns
  // at the WB negedge. abort=1 leaves the model untouched (reset follows).
  task automatic issue(input logic [15:0] w, input bit abort);
    logic [7:0] a, b;
    logic [2:0] sh;
    int         waited;
    waited = 0;
    @(negedge clk);
    while (!instr_ready && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    check("ready_before_issue", instr_ready, 1);
    operands(w, a, b, sh);
    if (!abort) predict(w);
    instr_valid = 1'b1;
    instr       = w;
    @(negedge clk);
    check("issue_ready", instr_ready, 0);
    check("issue_alu_a", alu_a, a);
    check("issue_alu_b", alu_b, b);
    check("issue_alu_op", alu_op, w[15:13]);
    check("issue_shamt", alu_shamt, sh);
    // Activity on the instruction port outside IDLE must be ignored.
    instr = 16'($urandom);
    @(negedge clk);
    check("wb_ready", instr_ready, 0);
    check("wb_alu_idle", {alu_a, alu_b, alu_op, alu_shamt}, 0);
    instr_valid = 1'b0;
    instr       = 16'h0000;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 20) begin
      @(negedge clk);
      #3;
      n++;
    end
    check("drain", sb.size(), 0);
  endtask

  task automatic read_reg(input string tag, input logic [1:0] r, input logic [7:0] exp_v);
    rd_sel = r;
    #1;
    check(tag, rd_data, exp_v);
  endtask

  // Scoreboard consumer: every done pulse must match the oldest expectation.
  always @(negedge clk) begin
    if (done === 1'b1) begin
      done_cnt++;
      if (sb.size() == 0) begin
        check("unexpected_done", 32'(done), 0);
      end else begin
        mon_e  = sb.pop_front();
        rd_sel = mon_e.rd;
        #1;
        check("done_rd_data", rd_data, mon_e.val);
        check("done_flags", flags, mon_e.flg);
        check("done_latency", cyc - mon_e.hs, 3);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] stream [4];
    int          base;

    rst_n       = 1'b0;
    instr_valid = 1'b0;
    instr       = 16'h0000;
    rd_sel      = 2'd0;
    for (int i = 0; i < 4; i++) mreg[i] = 8'h00;

    // Reset state.
    repeat (2) @(negedge clk);
    for (int i = 0; i < 4; i++) read_reg($sformatf("reset_r%0d", i), 2'(i), 8'h00);
    check("reset_flags", flags, 0);
    check("reset_done", done, 0);
    check("reset_ready", instr_ready, 1);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("ready_after_release", instr_ready, 1);

`ifdef ALU_ISSUE_IMM_EN
    issue(enc_i(OP_ORR, 2'd1, 2'd0, 8'hF0), 0);
    issue(enc_i(OP_ORR, 2'd2, 2'd0, 8'h20), 0);
    issue(enc_r(OP_ADD, 2'd3, 2'd1, 2'd2, 3'd0), 0);
    drain();
    read_reg("add_r3", 2'd3, 8'h10);
    check("add_flags", flags, 4'b0011);
    issue(enc_i(OP_ORR, 2'd1, 2'd0, 8'h55), 0);
    issue(enc_r(OP_SUB, 2'd0, 2'd1, 2'd1, 3'd0), 0);
    drain();
    read_reg("sub_r0", 2'd0, 8'h00);
    check("sub_z", flags[3], 1);
    issue(enc_i(OP_ORR, 2'd2, 2'd0, 8'h21), 0);
    issue(enc_r(OP_LSL, 2'd2, 2'd2, 2'd0, 3'd3), 0);
    drain();
    read_reg("lsl_r2", 2'd2, 8'h08);
    check("lsl_v", flags[0], 1);
    // Immediate shift takes its amount from instr[2:0].
    issue(enc_i(OP_LSL, 2'd3, 2'd2, 8'h01), 0);
    drain();
    read_reg("lsl_imm_r3", 2'd3, 8'h10);
`else
    issue(enc_r(OP_MVN, 2'd1, 2'd0, 2'd0, 3'd0), 0);
    issue(enc_r(OP_LSR, 2'd2, 2'd1, 2'd0, 3'd2), 0);
    issue(enc_r(OP_ADD, 2'd3, 2'd1, 2'd2, 3'd0), 0);
    drain();
    read_reg("add_r3", 2'd3, 8'h3E);
    check("add_flags", flags, 4'b0011);
    issue(enc_r(OP_SUB, 2'd0, 2'd1, 2'd1, 3'd0), 0);
    drain();
    read_reg("sub_r0", 2'd0, 8'h00);
    check("sub_z", flags[3], 1);
    issue(enc_r(OP_LSL, 2'd2, 2'd2, 2'd0, 3'd3), 0);
    drain();
    read_reg("lsl_r2", 2'd2, 8'hF8);
    check("lsl_v", flags[0], 1);
    // instr[12] set: still register form, so rb = r2 (0xF8), not imm 0x02.
    issue({OP_AND, 1'b1, 2'd3, 2'd1, 8'h02}, 0);
    drain();
    read_reg("imm_ignored_r3", 2'd3, 8'hF8);
`endif

    // rd == ra == rb: reads the old value, writes the new one.
    issue(enc_r(OP_ADD, 2'd1, 2'd1, 2'd1, 3'd0), 0);
    drain();

    // Continuous instr_valid: ready on every third cycle, four retirements.
    stream[0] = enc_r(OP_ADD, 2'd1, 2'd1, 2'd2, 3'd0);
    stream[1] = enc_r(OP_EOR, 2'd2, 2'd1, 2'd3, 3'd0);
    stream[2] = enc_r(OP_LSR, 2'd3, 2'd1, 2'd0, 3'd1);
    stream[3] = enc_r(OP_SUB, 2'd0, 2'd2, 2'd3, 3'd0);
    base = done_cnt;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      check($sformatf("stream_ready_%0d", k), instr_ready, ((k % 3) == 0) ? 1 : 0);
      if ((k % 3) == 0) begin
        instr = stream[k / 3];
        predict(instr);
        instr_valid = 1'b1;
      end else if (k == 10) begin
        instr_valid = 1'b0;
      end else begin
        instr = 16'($urandom);
      end
    end
    @(negedge clk);
    #3;
    check("stream_done_count", done_cnt - base, 4);
    instr_valid = 1'b0;
    drain();

    // Reset during WB aborts the write and the done pulse.
    base = done_cnt;
    issue(enc_r(OP_ADD, 2'd1, 2'd2, 2'd3, 3'd0), 1);
    #1;
    rst_n = 1'b0;
    for (int i = 0; i < 4; i++) mreg[i] = 8'h00;
    #1;
    check("abort_ready", instr_ready, 1);
    check("abort_done", done, 0);
    check("abort_flags", flags, 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("abort_ready_after_release", instr_ready, 1);
    for (int i = 0; i < 4; i++) read_reg($sformatf("abort_r%0d", i), 2'(i), 8'h00);
    repeat (4) @(negedge clk);
    #3;
    check("abort_no_done", done_cnt - base, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_issue.md
ALU_ISSUE -- requirements
Module: alu_issue

Interface
REQ-001 SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-002 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-003 SHALL have port instr_valid, input, 1 bit: instr holds a valid instruction word.
REQ-004 SHALL have port instr, input, 16 bits: [15:13] op, [12] imm, [11:10] rd, [9:8] ra, [7:0] rb/shamt (register form) or imm8 (immediate form).
REQ-005 SHALL have port instr_ready, output, 1 bit: block can accept an instruction this cycle.
REQ-006 SHALL have ports alu_a, alu_b (output, 8 bits each), alu_op (output, 3 bits) and alu_shamt (output, 3 bits): operands and controls driven to the ALU.
REQ-007 SHALL have ports alu_out (input, 8 bits) and alu_flags (input, 4 bits): ALU registered result and flags, Z=bit 3, N=2, C=1, V=0.
REQ-008 SHALL have port flags, output, 4 bits: architectural flag register.
REQ-009 SHALL have port done, output, 1 bit: one-cycle pulse when an instruction has retired.
REQ-010 SHALL have ports rd_sel (input, 2 bits) and rd_data (output, 8 bits): combinational read of register rd_sel.

Function
REQ-011 SHALL contain four 8-bit registers r0..r3, all writable.
REQ-012 SHALL implement FSM IDLE -> ISSUE -> WB -> IDLE with no other states.
REQ-013 instr_ready SHALL be 1 only in IDLE; a handshake (instr_valid & instr_ready) SHALL latch instr and move to ISSUE; otherwise IDLE holds.
REQ-014 In ISSUE: alu_a = r[ra]; alu_op = op unchanged (ALU_OP_* encoding); register form: alu_b = r[rb[1:0]] with rb = instr[1:0], alu_shamt = instr[4:2].
REQ-015 In IDLE and WB, alu_a, alu_b, alu_op and alu_shamt SHALL be 0.
REQ-016 In WB, r[rd] SHALL load alu_out and flags SHALL load alu_flags at the end of the cycle.
REQ-017 done SHALL be registered, 1 in the cycle after WB only; the written value SHALL be visible on rd_data in that cycle.
REQ-018 Latency SHALL be 3 cycles from handshake to done; throughput SHALL be one instruction per 3 cycles; a new handshake MAY coincide with done.
REQ-019 rd == ra or rd == rb SHALL read old operands in ISSUE and write the new value in WB; no hazard logic SHALL exist.
REQ-020 instr_valid or instr changing while not in IDLE SHALL have no effect.

Reset
REQ-021 rst_n low SHALL asynchronously force state IDLE, r0..r3 = 0x00, flags = 0x0, done = 0, and latched instr = 0x0000.
REQ-022 Reset during ISSUE or WB SHALL abort the instruction with no register or flag write and no done pulse.
REQ-023 After reset release, instr_ready SHALL be 1 in the first cycle.

Configuration
REQ-024 Macro ALU_ISSUE_IMM_EN defined: instr[12] = 1 SHALL select immediate form, with alu_b = instr[7:0] and alu_shamt = instr[2:0]; instr[12] = 0 SHALL select register form.
REQ-025 ALU_ISSUE_IMM_EN undefined: instr[12] SHALL be ignored and register form SHALL always be used.

Verification
REQ-026 Reset, then rd_sel = 0..3 -> rd_data = 0x00 for all, flags = 0x0, instr_ready = 1.
REQ-027 (IMM_EN) Load r1 = 0xF0 and r2 = 0x20 via immediate ORR with r0, then register ADD r3 = r1 + r2 -> r3 = 0x10, flags V = 1, Z = 0, done 3 cycles after the handshake.
REQ-028 SUB r0 = r1 - r1 with r1 = 0x55 -> r0 = 0x00, flags Z = 1.
REQ-029 LSL r2 = r2 << 3 (register form, shamt field 3) with r2 = 0x21 -> r2 = 0x08, V = 1.
REQ-030 Hold instr_valid high continuously for 4 instructions -> instr_ready pattern 1,0,0,1,...; exactly 4 done pulses in 12 cycles.
REQ-031 Assert rst_n low during WB of ADD r1 -> r1 stays 0x00, no done pulse, state IDLE.
